io_bus_bridge: RTL and testbench
================================

// Module: io_bus_bridge
// PURPOSE
// - Downstream of the miniRV core's MEM stage. Consumes mem_addr/mem_ctrl/mem_wd/mem_we/mem_rd.
// - Decodes each access to either data DRAM or the memory-mapped peripheral page (0xFFFF_F000-0xFFFF_FFFF).
// - Forms DRAM byte enables and returns sign/zero-extended read data combinationally, in the same cycle.
// - Owns the peripherals: LED register, synchronized switch input, 8-digit 7-seg scanner.
// PARAMETERS
// - ADDR_W    32         width of mem_addr (= IO_BUS_WIDTH_ADDR)
// - DATA_W    32         width of mem_wd / mem_rd (= IO_BUS_WIDTH_DATA)
// - CTRL_W    4          width of mem_ctrl (= IO_BUS_WIDTH_CTRL)
// - DRAM_AW   14         DRAM word-address width; dram_addr = mem_addr[DRAM_AW+1:2]
// - SCAN_DIV  16'd50000  clk cycles per display digit slot (must be >= 2)
// PORTS
// - clk          in   1        single system clock; all state updates on posedge
// - rst          in   1        asynchronous, active-high reset
// - mem_addr     in   ADDR_W   byte address from core MEM stage
// - mem_ctrl     in   CTRL_W   {unsigned, size[1:0], we}; size 00=byte, 01=half, 10=word
// - mem_wd       in   DATA_W   store data, right-aligned
// - mem_we       in   1        store strobe (mirrors mem_ctrl[0])
// - mem_rd       out  DATA_W   load data, extended and right-aligned; combinational
// - dram_addr    out  DRAM_AW  DRAM word address
// - dram_be      out  4        DRAM byte write enables; 0 when not a DRAM store
// - dram_wdata   out  32       store data shifted into byte lanes
// - dram_rdata   in   32       DRAM read word; combinational/asynchronous read
// - sw_in        in   24       raw board switches (asynchronous)
// - led_o        out  24       LED register
// - dn_an        out  8        digit anodes, active-low one-hot
// - dn_seg       out  8        segments {a,b,c,d,e,f,g,dp}, active-low
// BEHAVIOUR
// - Address map, using mem_addr[11:0] when mem_addr[31:12] = 20'hFFFFF:
//   - 0x000 DISP: RW, 8 hex nibbles shown on the display.
//   - 0x060 LED:  RW, bits [23:0].
//   - 0x070 SW:   RO, {8'b0, sw_sync}.
//   - Any other IO offset reads 0; stores to it are ignored.
//   - All other addresses decode to DRAM.
// - Lane and alignment: lane = mem_addr[1:0]. Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. Misaligned accesses are never trapped.
// - Store byte enables:
//   - byte: be = 1<<lane
//   - half: be = 4'b0011 << {lane[1],1'b0}
//   - word: be = 4'b1111
//   - wdata = mem_wd replicated into the selected lanes.
// - IO stores apply the same byte enables to the target register; the register updates on the next posedge. SW is not writable.
// - Loads extract the selected byte or half, then zero-extend if mem_ctrl[3]=1, otherwise sign-extend. Same-cycle combinational path from dram_rdata or the IO register to mem_rd.
// - Load/store to the same IO register in one cycle: mem_rd returns the old value.
// - Switch sync: two flops. A sw_in change is visible at SW on the 2nd posedge after the change.
// - Display scanner:
//   - div counts 0..SCAN_DIV-1, then wraps to 0; on the wrap, idx advances 0..7, wrapping 7 to 0.
//   - dn_an = ~(8'b1 << idx).
//   - dn_seg = decode(DISP[4*idx+3 -: 4]) with dp off. Both are registered, so they lag idx by 1 cycle.
// - Reset values (async, on rst rising, and held while rst=1): DISP=0, LED=0, sw_sync=0, div=0, idx=0, dn_an=8'hFE, dn_seg=8'h03 (glyph '0').
// - Reset mid-store: the store is lost. Reset mid-scan: the scan restarts at digit 0.
// CONFIGURATION
// - Macro IO_TIMER_EN.
// - Defined: adds TIMER at IO offset 0x020, a 32-bit counter that increments every clk.
//   - Any store to TIMER clears it to 0 on the next posedge; the store data is ignored.
//   - Reset value 0. Wraps 0xFFFFFFFF -> 0.
// - Undefined: offset 0x020 behaves as unmapped (reads 0, stores ignored); no counter logic is built.
// STRUCTURE
// - param.v gains:
//   - IO base 32'hFFFF_F000 and offsets DISP/TIMER/LED/SW
//   - size codes SIZE_B/SIZE_H/SIZE_W
//   - mem_ctrl bit positions
// - Sub-module seg7_decode: combinational 4-bit nibble -> 8-bit active-low segments.
// - Address decode, lane logic and registers live in io_bus_bridge.
// TESTING
// - Store word 0x12345678 to 0x100, then lb 0x103 with unsigned=0 -> mem_rd=0x00000012; lbu -> 0x12.
// - sb 0xAB to 0x101 -> dram_be=4'b0010, dram_wdata=0xABABABAB; lh 0x102 of word 0x80010000 -> 0xFFFF8001.
// - sw_in=24'h00A5A5 -> load 0xFFFFF070 returns 0 on the 1st posedge after the change and 0x00A5A5 from the 2nd; store 0x0F to 0xFFFFF060 -> led_o=0x00000F next cycle.
// - DISP=0x0000_00F1, SCAN_DIV=2 -> dn_an steps FE,FD,FB,...,7F,FE every 2 cycles; slot 0 segs='1'; slot 1 segs='F'; slots 2-7 segs='0'.
// - Assert rst mid-scan with LED=0xFFFFFF -> immediately LED=0, dn_an=FE, dn_seg=03; no dram_be activity.
// - IO_TIMER_EN: read 0xFFFFF020 after 10 cycles out of reset -> 10; store -> next read 1; without the macro, reads 0.

Source files
------------

// File: rtl/io_bus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// io_bus_bridge_pkg
// Shared definitions for the miniRV MEM-stage IO/DRAM bridge:
//   - bus widths, IO page base and register offsets
//   - access size codes and mem_ctrl bit positions
//   - lane helpers: store byte enables, store data replication and load
//     extraction/extension
// The optional TIMER register (offset TIMER) is only decoded when the
// IO_TIMER_EN macro is defined; its offset lives here unconditionally.
// -----------------------------------------------------------------------------
package io_bus_bridge_pkg;

   localparam int IO_BUS_WIDTH_ADDR = 32;
   localparam int IO_BUS_WIDTH_DATA = 32;
   localparam int IO_BUS_WIDTH_CTRL = 4;

   localparam logic [31:0] IO_BASE = 32'hFFFF_F000;
   localparam logic [19:0] IO_PAGE = IO_BASE[31:12];

   localparam logic [11:0] OFF_DISP  = 12'h000;
   localparam logic [11:0] OFF_TIMER = 12'h020;
   localparam logic [11:0] OFF_LED   = 12'h060;
   localparam logic [11:0] OFF_SW    = 12'h070;

   // mem_ctrl = {unsigned, size[1:0], we}
   localparam int CTRL_WE      = 0;
   localparam int CTRL_SIZE_LO = 1;
   localparam int CTRL_SIZE_HI = 2;
   localparam int CTRL_UNS     = 3;

   localparam int SEG_W = 8;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10
   } size_e;

   typedef enum logic [2:0] {
      IO_NONE,
      IO_DISP,
      IO_TIMER,
      IO_LED,
      IO_SW
   } io_sel_e;

   // Byte enables for a store; size code 2'b11 is treated as a word.
   function automatic logic [3:0] lane_be(input logic [1:0] size,
                                          input logic [1:0] lane);
      case (size)
         SIZE_B:  return 4'b0001 << lane;
         SIZE_H:  return 4'b0011 << {lane[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   // Right-aligned store data replicated so every candidate lane carries it.
   function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                              input logic [31:0] wd);
      case (size)
         SIZE_B:  return {4{wd[7:0]}};
         SIZE_H:  return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   // Pick the addressed byte/half out of a word and extend it.
   function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        uns,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (size)
         SIZE_B:  return uns ? {24'd0, b} : {{24{b[7]}}, b};
         SIZE_H:  return uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/io_bus_bridge_if.sv
// -----------------------------------------------------------------------------
// io_bus_bridge_if
// Groups the core MEM-stage access signals and the DRAM port.
//   mem_addr/mem_ctrl/mem_wd/mem_we : access request from the core
//   mem_rd                          : extended load data back to the core
//   dram_addr/dram_be/dram_wdata    : DRAM word address, lane enables, data
//   dram_rdata                      : asynchronous DRAM read word
// Modports: master = core + DRAM side, slave = the bridge.
// -----------------------------------------------------------------------------
interface io_bus_bridge_if
   import io_bus_bridge_pkg::*;
#(
   parameter int ADDR_W  = IO_BUS_WIDTH_ADDR,
   parameter int DATA_W  = IO_BUS_WIDTH_DATA,
   parameter int CTRL_W  = IO_BUS_WIDTH_CTRL,
   parameter int DRAM_AW = 14
) ();

   logic [ADDR_W-1:0]  mem_addr;
   logic [CTRL_W-1:0]  mem_ctrl;
   logic [DATA_W-1:0]  mem_wd;
   logic               mem_we;
   logic [DATA_W-1:0]  mem_rd;
   logic [DRAM_AW-1:0] dram_addr;
   logic [3:0]         dram_be;
   logic [31:0]        dram_wdata;
   logic [31:0]        dram_rdata;

   modport master (
      output mem_addr, mem_ctrl, mem_wd, mem_we, dram_rdata,
      input  mem_rd, dram_addr, dram_be, dram_wdata
   );

   modport slave (
      input  mem_addr, mem_ctrl, mem_wd, mem_we, dram_rdata,
      output mem_rd, dram_addr, dram_be, dram_wdata
   );

endinterface

// File: rtl/io_bus_bridge_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational hex nibble to 7-segment glyph, active-low.
//   nib_i : 4-bit value 0..F
//   seg_o : {a,b,c,d,e,f,g,dp}, active-low; dp is always off (1)
// -----------------------------------------------------------------------------
module seg7_decode
   import io_bus_bridge_pkg::*;
(
   input  logic [3:0]       nib_i,
   output logic [SEG_W-1:0] seg_o
);

   always_comb begin
      seg_o = 8'hFF;
      case (nib_i)
         4'h0: seg_o = 8'h03;
         4'h1: seg_o = 8'h9F;
         4'h2: seg_o = 8'h25;
         4'h3: seg_o = 8'h0D;
         4'h4: seg_o = 8'h99;
         4'h5: seg_o = 8'h49;
         4'h6: seg_o = 8'h41;
         4'h7: seg_o = 8'h1F;
         4'h8: seg_o = 8'h01;
         4'h9: seg_o = 8'h09;
         4'hA: seg_o = 8'h11;
         4'hB: seg_o = 8'hC1;
         4'hC: seg_o = 8'h63;
         4'hD: seg_o = 8'h85;
         4'hE: seg_o = 8'h61;
         4'hF: seg_o = 8'h71;
         default: seg_o = 8'hFF;
      endcase
   end

endmodule

// File: rtl/io_bus_bridge.sv
// -----------------------------------------------------------------------------
// io_bus_bridge
// Sits behind the miniRV MEM stage. Each access is decoded to DRAM or to the
// peripheral page 0xFFFF_F000-0xFFFF_FFFF; load data is extracted and
// extended combinationally in the same cycle.
//   clk, rst   : system clock, asynchronous active-high reset
//   bus        : io_bus_bridge_if.slave (core access + DRAM port)
//   sw_in      : raw board switches, two-flop synchronized
//   led_o      : LED register
//   dn_an      : digit anodes, active-low one-hot
//   dn_seg     : segments {a..g,dp}, active-low
// IO registers: DISP 0x000 (RW), LED 0x060 (RW), SW 0x070 (RO).
// Optional macro IO_TIMER_EN adds TIMER at 0x020: free-running 32-bit counter,
// cleared by any store. Without it 0x020 is unmapped.
// -----------------------------------------------------------------------------
module io_bus_bridge
   import io_bus_bridge_pkg::*;
#(
   parameter int          ADDR_W   = IO_BUS_WIDTH_ADDR,
   parameter int          DATA_W   = IO_BUS_WIDTH_DATA,
   parameter int          CTRL_W   = IO_BUS_WIDTH_CTRL,
   parameter int          DRAM_AW  = 14,
   parameter logic [15:0] SCAN_DIV = 16'd50000
) (
   input  logic                 clk,
   input  logic                 rst,
   io_bus_bridge_if.slave       bus,
   input  logic [23:0]          sw_in,
   output logic [23:0]          led_o,
   output logic [7:0]           dn_an,
   output logic [SEG_W-1:0]     dn_seg
);

   logic [CTRL_W-1:0] ctrl;
   logic [1:0]        size;
   logic [1:0]        lane;
   logic              uns;
   logic              is_io;
   logic [11:0]       io_off;
   io_sel_e           io_sel;
   logic [3:0]        be;
   logic [31:0]       wdata_lanes;
   logic [31:0]       wmask;
   logic              io_we;
   logic              dram_we;
   logic [31:0]       io_rdata;
   logic [DATA_W-1:0] rword;
   logic              unused_ctrl;

   logic [31:0]       disp_q, disp_d;
   logic [23:0]       led_q, led_d;
   logic [23:0]       sw_meta_q, sw_sync_q;
   logic [15:0]       div_q, div_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        an_q, an_d;
   logic [SEG_W-1:0]  seg_q, seg_d;
   logic [3:0]        nibble;

   assign ctrl        = bus.mem_ctrl;
   assign size        = ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO];
   assign uns         = ctrl[CTRL_UNS];
   // mem_we is the store strobe; ctrl[CTRL_WE] only mirrors it.
   assign unused_ctrl = ctrl[CTRL_WE];
   assign lane        = bus.mem_addr[1:0];

   assign is_io  = (bus.mem_addr[ADDR_W-1:12] == IO_PAGE);
   // Registers are word-decoded so byte/half accesses hit the same register.
   assign io_off = {bus.mem_addr[11:2], 2'b00};

   always_comb begin
      io_sel = IO_NONE;
      if (is_io) begin
         case (io_off)
            OFF_DISP:  io_sel = IO_DISP;
`ifdef IO_TIMER_EN
            OFF_TIMER: io_sel = IO_TIMER;
`endif
            OFF_LED:   io_sel = IO_LED;
            OFF_SW:    io_sel = IO_SW;
            default:   io_sel = IO_NONE;
         endcase
      end
   end

   assign be          = lane_be(size, lane);
   assign wdata_lanes = lane_wdata(size, bus.mem_wd);
   assign wmask       = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

   assign io_we   = bus.mem_we & is_io;
   // Gating with rst keeps a store that overlaps reset from reaching DRAM.
   assign dram_we = bus.mem_we & ~is_io & ~rst;

   assign bus.dram_addr  = bus.mem_addr[DRAM_AW+1:2];
   assign bus.dram_be    = dram_we ? be : 4'b0000;
   assign bus.dram_wdata = wdata_lanes;

`ifdef IO_TIMER_EN
   logic [31:0] timer_q, timer_d;

   // A store of any size or data restarts the count from zero.
   assign timer_d = (io_we && io_sel == IO_TIMER) ? 32'd0 : timer_q + 32'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`endif

   // Read path always shows pre-edge register contents, so a same-cycle
   // load/store of one register returns the old value.
   always_comb begin
      io_rdata = 32'd0;
      case (io_sel)
         IO_DISP:  io_rdata = disp_q;
         IO_LED:   io_rdata = {8'd0, led_q};
         IO_SW:    io_rdata = {8'd0, sw_sync_q};
`ifdef IO_TIMER_EN
         IO_TIMER: io_rdata = timer_q;
`endif
         default:  io_rdata = 32'd0;
      endcase
   end

   assign rword      = is_io ? io_rdata : bus.dram_rdata;
   assign bus.mem_rd = load_extend(size, lane, uns, rword);

   always_comb begin
      disp_d = disp_q;
      led_d  = led_q;
      if (io_we && io_sel == IO_DISP) begin
         disp_d = (disp_q & ~wmask) | (wdata_lanes & wmask);
      end
      if (io_we && io_sel == IO_LED) begin
         led_d = (led_q & ~wmask[23:0]) | (wdata_lanes[23:0] & wmask[23:0]);
      end
   end

   // Scanner: idx moves to the next digit when div wraps.
   always_comb begin
      div_d = div_q + 16'd1;
      idx_d = idx_q;
      if (div_q == SCAN_DIV - 16'd1) begin
         div_d = 16'd0;
         idx_d = idx_q + 3'd1;
      end
   end

   assign nibble = disp_q[{idx_q, 2'b00} +: 4];
   assign an_d   = ~(8'd1 << idx_q);

   seg7_decode u_seg7 (
      .nib_i (nibble),
      .seg_o (seg_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_q    <= '0;
         led_q     <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         div_q     <= '0;
         idx_q     <= '0;
         an_q      <= 8'hFE;
         seg_q     <= 8'h03;
      end else begin
         disp_q    <= disp_d;
         led_q     <= led_d;
         sw_meta_q <= sw_in;
         sw_sync_q <= sw_meta_q;
         div_q     <= div_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign led_o  = led_q;
   assign dn_an  = an_q;
   assign dn_seg = seg_q;

endmodule

// File: tb/tb_io_bus_bridge.sv
module tb_io_bus_bridge;

   logic        clk;
   logic        rst;
   logic [23:0] sw_in;
   logic [23:0] led_o;
   logic [7:0]  dn_an;
   logic [7:0]  dn_seg;

   io_bus_bridge_if bus ();

   io_bus_bridge #(.SCAN_DIV(16'd2)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .sw_in  (sw_in),
      .led_o  (led_o),
      .dn_an  (dn_an),
      .dn_seg (dn_seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bench-side DRAM, written from the DUT's byte enables.
   logic [31:0] dram_mem [0:16383] = '{default: 32'h0};
   assign bus.dram_rdata = dram_mem[bus.dram_addr];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (bus.dram_be[i]) dram_mem[bus.dram_addr][8*i +: 8] <= bus.dram_wdata[8*i +: 8];
      end
   end

   // ---------------- reference model ----------------
   logic [7:0]  ref_b [0:65535] = '{default: 8'h0};
   logic [31:0] ref_disp = 0;
   logic [23:0] ref_led = 0;
   int unsigned tmr_base = 0;
   logic [23:0] sw_old = 0, sw_new = 0;
   int unsigned sw_chg = 0;
   // abcdefg, active-high
   logic [6:0]  glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] sw_vis();
      return (cyc - sw_chg >= 2) ? sw_new : sw_old;
   endfunction

   function automatic logic [31:0] ref_io_word(input logic [31:0] a);
      case ({a[11:2], 2'b00})
         12'h000: return ref_disp;
         12'h060: return {8'h00, ref_led};
         12'h070: return {8'h00, sw_vis()};
`ifdef IO_TIMER_EN
         12'h020: return cyc - tmr_base;
`endif
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
      if (sz == 2'd0) return 4'(1 << a[1:0]);
      if (sz == 2'd1) return 4'(3 << (a[1] * 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_rep(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
      logic [31:0] w, v;
      logic [15:0] base;
      int n;
      if (a[31:12] == 20'hFFFFF) begin
         w = ref_io_word(a);
         if (sz == 2'd0) w = w >> (a[1:0] * 8);
         else if (sz == 2'd1) w = w >> (a[1] * 16);
      end else begin
         n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
         base = (sz == 2'd0) ? a[15:0] : (sz == 2'd1) ? {a[15:1], 1'b0} : {a[15:2], 2'b00};
         w = 0;
         for (int i = 0; i < n; i++) w = w | (32'(ref_b[base + 16'(i)]) << (8 * i));
      end
      if (sz == 2'd0) begin
         v = w & 32'hFF;
         if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = w & 32'hFFFF;
         if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      logic [3:0]  be;
      logic [31:0] rep, w;
      be  = ref_be(a, sz);
      rep = ref_rep(sz, wd);
      if (a[31:12] == 20'hFFFFF) begin
         case ({a[11:2], 2'b00})
            12'h000: begin
               for (int i = 0; i < 4; i++) if (be[i]) ref_disp[8*i +: 8] = rep[8*i +: 8];
            end
            12'h060: begin
               w = {8'h00, ref_led};
               for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = rep[8*i +: 8];
               ref_led = w[23:0];
            end
`ifdef IO_TIMER_EN
            12'h020: tmr_base = cyc;
`endif
            default: ;
         endcase
      end else begin
         for (int i = 0; i < 4; i++)
            if (be[i]) ref_b[{a[15:2], 2'b00} + 16'(i)] = rep[8*i +: 8];
      end
   endtask

   // One bus cycle: drive at posedge+1, check combinational outputs, commit.
   task automatic access(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input logic we, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [3:0] obe, output logic [31:0] owd);
      logic [3:0] exp_be;
      bus.mem_addr = a;
      bus.mem_ctrl = {uns, sz, we};
      bus.mem_wd   = wd;
      bus.mem_we   = we;
      #1;
      exp_be = (we && a[31:12] != 20'hFFFFF) ? ref_be(a, sz) : 4'h0;
      check("mem_rd", bus.mem_rd, ref_load(a, sz, uns));
      check("dram_be", {28'd0, bus.dram_be}, {28'd0, exp_be});
      check("dram_addr", {18'd0, bus.dram_addr}, {18'd0, a[15:2]});
      if (exp_be != 4'h0) check("dram_wdata", bus.dram_wdata, ref_rep(sz, wd));
      rd  = bus.mem_rd;
      obe = bus.dram_be;
      owd = bus.dram_wdata;
      @(posedge clk);
      #1;
      if (we) ref_store(a, sz, wd);
      bus.mem_we   = 1'b0;
      bus.mem_ctrl = {uns, sz, 1'b0};
      check("led_o", {8'd0, led_o}, {8'd0, ref_led});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, owd, a, wd;
      logic [3:0]  obe;
      logic [1:0]  sz;
      int unsigned c0, k, slot, pick;
      logic [11:0] offs [6];

      offs = '{12'h000, 12'h020, 12'h060, 12'h070, 12'h040, 12'hFFC};

      rst = 1'b0;
      sw_in = 24'h0;
      bus.mem_addr = 32'h0;
      bus.mem_ctrl = 4'h0;
      bus.mem_wd = 32'h0;
      bus.mem_we = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("rst_led", {8'd0, led_o}, 32'h0);
      check("rst_an", {24'd0, dn_an}, 32'hFE);
      check("rst_seg", {24'd0, dn_seg}, 32'h03);
      check("rst_be", {28'd0, bus.dram_be}, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_hold_an", {24'd0, dn_an}, 32'hFE);
      rst = 1'b0;
      tmr_base = cyc;
      sw_old = 0; sw_new = sw_in; sw_chg = cyc;

      // timer
      repeat (10) @(posedge clk);
      #1;
      access(32'hFFFF_F020, 2'd2, 1'b0, 1'b0, 32'h0, rd, obe, owd);
`ifdef IO_TIMER_EN
      check("timer_10", rd, 32'd10);
`else
      check("timer_off", rd, 32'd0);
`endif
      access(32'hFFFF_F020, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF, rd, obe, owd);
      @(posedge clk); #1;
      access(32'hFFFF_F020, 2'd2, 1'b0, 1'b0, 32'h0, rd, obe, owd);
`ifdef IO_TIMER_EN
      check("timer_clr", rd, 32'd1);
`else
      check("timer_off2", rd, 32'd0);
`endif

      // DRAM lanes and extension
      access(32'h0000_0100, 2'd2, 1'b0, 1'b1, 32'h1234_5678, rd, obe, owd);
      check("sw_be", {28'd0, obe}, 32'hF);
      access(32'h0000_0103, 2'd0, 1'b0, 1'b0, 32'h0, rd, obe, owd);
      check("lb_103", rd, 32'h0000_0012);
      access(32'h0000_0103, 2'd0, 1'b1, 1'b0, 32'h0, rd, obe, owd);
      check("lbu_103", rd, 32'h0000_0012);
      access(32'h0000_0101, 2'd0, 1'b0, 1'b1, 32'h0000_00AB, rd, obe, owd);
      check("sb_be", {28'd0, obe}, 32'h2);
      check("sb_wdata", owd, 32'hABAB_ABAB);
      access(32'h0000_0200, 2'd2, 1'b0, 1'b1, 32'h8001_0000, rd, obe, owd);
      access(32'h0000_0202, 2'd1, 1'b0, 1'b0, 32'h0, rd, obe, owd);
      check("lh_202", rd, 32'hFFFF_8001);

      // switch synchronizer
      sw_old = sw_vis(); sw_new = 24'h00A5A5; sw_chg = cyc;
      sw_in = 24'h00A5A5;
      access(32'hFFFF_F070, 2'd2, 1'b0, 1'b0, 32'h0, rd, obe, owd);
      check("sw_0", rd, 32'h0);
      access(32'hFFFF_F070, 2'd2, 1'b0, 1'b0, 32'h0, rd, obe, owd);
      check("sw_1", rd, 32'h0);
      access(32'hFFFF_F070, 2'd2, 1'b0, 1'b0, 32'h0, rd, obe, owd);
      check("sw_2", rd, 32'h0000_A5A5);

      // LED
      access(32'hFFFF_F060, 2'd2, 1'b0, 1'b1, 32'h0000_000F, rd, obe, owd);
      check("led_0f", {8'd0, led_o}, 32'h0000_000F);

      // randomized traffic
      for (int n = 0; n < 250; n++) begin
         sz = 2'($urandom_range(0, 2));
         wd = $urandom;
         if ($urandom_range(0, 9) < 6) begin
            a = $urandom;
            if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
         end else begin
            pick = $urandom_range(0, 5);
            a = 32'hFFFF_F000 | {20'd0, offs[pick]} | ($urandom & 32'h3);
         end
         access(a, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wd, rd, obe, owd);
      end

      // reset in the middle of a scan and a pending store
      access(32'hFFFF_F060, 2'd2, 1'b0, 1'b1, 32'h00FF_FFFF, rd, obe, owd);
      check("led_ff", {8'd0, led_o}, 32'h00FF_FFFF);
      bus.mem_addr = 32'h0000_0300;
      bus.mem_ctrl = {1'b0, 2'd2, 1'b1};
      bus.mem_wd   = 32'hCAFE_F00D;
      bus.mem_we   = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      ref_disp = 0; ref_led = 0;
      #1;
      check("mid_led", {8'd0, led_o}, 32'h0);
      check("mid_an", {24'd0, dn_an}, 32'hFE);
      check("mid_seg", {24'd0, dn_seg}, 32'h03);
      check("mid_be", {28'd0, bus.dram_be}, 32'h0);
      @(posedge clk); #1;
      check("mid_hold_led", {8'd0, led_o}, 32'h0);
      check("mid_hold_be", {28'd0, bus.dram_be}, 32'h0);
      bus.mem_we = 1'b0;
      bus.mem_ctrl = 4'h0;
      rst = 1'b0;
      c0 = cyc;
      tmr_base = cyc;
      sw_old = 0; sw_new = sw_in; sw_chg = cyc;

      // display scan
      access(32'hFFFF_F000, 2'd2, 1'b0, 1'b1, 32'h0000_00F1, rd, obe, owd);
      for (int n = 0; n < 18; n++) begin
         @(posedge clk); #1;
         k = cyc - c0;
         slot = ((k - 1) / 2) % 8;
         check("scan_an", {24'd0, dn_an}, {24'd0, ~(8'd1 << slot)});
         check("scan_seg", {24'd0, dn_seg},
               {24'd0, ~glyph[(ref_disp >> (4 * slot)) & 32'hF], 1'b1});
      end
      access(32'h0000_0300, 2'd2, 1'b0, 1'b0, 32'h0, rd, obe, owd);
      access(32'hFFFF_F070, 2'd2, 1'b0, 1'b0, 32'h0, rd, obe, owd);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
